// File: rtl/tff_lab_defs.sv
// Shared state encodings for the T flip-flop lab blocks.
// Debounce FSM states, also used by benches for state checks.
package tff_lab_defs;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CHK_PRESS = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] CHK_REL   = 2'd3;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level.
// Ports: clk, rst (async, active-high), d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/t_toggle_pulse_gen.sv
// Debounced push-button to single-cycle T pulse generator.
// Ports: clk, rst, btn_in -> T (pulse), pressed (level), toggle_cnt.
module t_toggle_pulse_gen
  import tff_lab_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b0,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             T,
  output logic             pressed,
  output logic [CNT_W-1:0] toggle_cnt
);
  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [QW-1:0] QMAX = QW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = IDLE,
    S_CHK_PRESS = CHK_PRESS,
    S_HELD      = HELD,
    S_CHK_REL   = CHK_REL
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic          btn_n;
  logic          s2;

  // Inversion ahead of the synchronizer keeps reset value inactive.
  assign btn_n = btn_in ^ BTN_ACTIVE_LOW;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_n),
    .q   (s2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      qcnt       <= '0;
      T          <= 1'b0;
      pressed    <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      T <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (s2) begin
            state <= S_CHK_PRESS;
            qcnt  <= '0;
          end
        end
        S_CHK_PRESS: begin
          if (!s2) begin
            state <= S_IDLE;
            qcnt  <= '0;
          end else if (qcnt == QMAX) begin
            state      <= S_HELD;
            T          <= 1'b1;
            pressed    <= 1'b1;
            toggle_cnt <= toggle_cnt + CNT_W'(1);
          end else begin
            qcnt <= qcnt + QW'(1);
          end
        end
        S_HELD: begin
          if (!s2) begin
            state <= S_CHK_REL;
            qcnt  <= '0;
          end
        end
        S_CHK_REL: begin
          // Return to HELD on bounce: no new pulse is issued.
          if (s2) begin
            state <= S_HELD;
            qcnt  <= '0;
          end else if (qcnt == QMAX) begin
            state   <= S_IDLE;
            pressed <= 1'b0;
          end else begin
            qcnt <= qcnt + QW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          qcnt  <= '0;
        end
      endcase
    end
  end
endmodule
